// File: rtl/fir_mul_pipe_if.sv
// rtl/fir_mul_pipe_if.sv - operand/result handshake bundle for fir_mul_pipe
interface fir_mul_pipe_if #(
  parameter int DIN0_W = 16,
  parameter int DIN1_W = 11,
  parameter int DOUT_W = 27
);
  logic [DIN0_W-1:0] din0;
  logic [DIN1_W-1:0] din1;
  logic              in_valid;
  logic              in_ready;
  logic [DOUT_W-1:0] dout;
  logic              sat;
  logic              out_valid;
  logic              out_ready;

  // Producer of operands and consumer of results (the tap logic around the multiplier)
  modport master (
    output din0, din1, in_valid, out_ready,
    input  in_ready, dout, sat, out_valid
  );

  // The multiplier itself
  modport slave (
    input  din0, din1, in_valid, out_ready,
    output in_ready, dout, sat, out_valid
  );
endinterface

// File: rtl/fir_mul_pipe.sv
// rtl/fir_mul_pipe.sv - pipelined signed/unsigned multiplier with scaling, rounding and saturation
module fir_mul_pipe #(
  parameter int DIN0_W      = 16,
  parameter int DIN1_W      = 11,
  parameter int DOUT_W      = 27,
  parameter int NUM_STAGE   = 3,
  parameter int DIN0_SIGNED = 1,
  parameter int DIN1_SIGNED = 0,
  parameter int SHIFT       = 0,
  parameter int ROUND       = 0,
  parameter int SAT         = 1
) (
  input logic          ap_clk,
  input logic          ap_rst_n,
  fir_mul_pipe_if.slave bus
);

  // Exact product width: both operands widened by one bit, then multiplied signed.
  localparam int P  = DIN0_W + DIN1_W + 2;
  // Final stage payload is {dout, sat}.
  localparam int FW = DOUT_W + 1;
  // Every stage carries one uniform payload wide enough for operands, product or result.
  localparam int W  = (P > FW) ? P : FW;
  // Scaling arithmetic width: one guard bit over the product for the rounding add,
  // and at least two bits over DOUT_W so the unsigned upper bound is representable.
  localparam int X0 = P + 1;
  localparam int X  = (X0 > DOUT_W + 2) ? X0 : DOUT_W + 2;

  localparam bit RES_SIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);
  localparam int RSH        = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [X-1:0] ONE_X = {{(X-1){1'b0}}, 1'b1};
  localparam logic signed [X-1:0] RND_X = ((ROUND != 0) && (SHIFT > 0)) ? (ONE_X <<< RSH) : '0;
  localparam logic signed [X-1:0] HI_X  = RES_SIGNED ? ((ONE_X <<< (DOUT_W - 1)) - ONE_X)
                                                     : ((ONE_X <<< DOUT_W) - ONE_X);
  localparam logic signed [X-1:0] LO_X  = RES_SIGNED ? -(ONE_X <<< (DOUT_W - 1)) : '0;

  // Widen each operand by one bit according to its signedness and pack them side by side.
  function automatic logic [P-1:0] pack_ops(input logic [DIN0_W-1:0] a,
                                            input logic [DIN1_W-1:0] b);
    logic [DIN0_W:0] ea;
    logic [DIN1_W:0] eb;
    ea = {((DIN0_SIGNED != 0) ? a[DIN0_W-1] : 1'b0), a};
    eb = {((DIN1_SIGNED != 0) ? b[DIN1_W-1] : 1'b0), b};
    return {ea, eb};
  endfunction

  // Signed multiply of the widened operands; P bits hold the product exactly.
  function automatic logic signed [P-1:0] mul_ops(input logic [P-1:0] ops);
    logic signed [DIN0_W:0] ea;
    logic signed [DIN1_W:0] eb;
    ea = ops[P-1:DIN1_W+1];
    eb = ops[DIN1_W:0];
    return P'(ea) * P'(eb);
  endfunction

  // Round, shift and clamp/wrap a product into {dout, sat}.
  // An unsigned-only result is never negative, so the arithmetic shift acts as a logical one.
  function automatic logic [FW-1:0] scale(input logic signed [P-1:0] prod);
    logic signed [X-1:0] v;
    logic                s;
    v = X'(prod) + RND_X;
    v = v >>> SHIFT;
    s = 1'b0;
    if (SAT != 0) begin
      if (v > HI_X) begin
        v = HI_X;
        s = 1'b1;
      end else if (v < LO_X) begin
        v = LO_X;
        s = 1'b1;
      end
    end
    return {v[DOUT_W-1:0], s};
  endfunction

  logic [NUM_STAGE-1:0] valid_q;
  logic [W-1:0]         data_q [NUM_STAGE];
  logic [W-1:0]         nxt    [NUM_STAGE];
  logic [NUM_STAGE-1:0] up_valid;
  logic [NUM_STAGE-1:0] load;

  // Per-stage next payload: operands in stage 1, product in the middle, scaled result last.
  for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign up_valid[k] = bus.in_valid;
      if (NUM_STAGE == 1) begin : g_all
        assign nxt[k] = W'(scale(mul_ops(pack_ops(bus.din0, bus.din1))));
      end else begin : g_ops
        assign nxt[k] = W'(pack_ops(bus.din0, bus.din1));
      end
    end else begin : g_rest
      assign up_valid[k] = valid_q[k-1];
      if (k == NUM_STAGE - 1) begin : g_last
        if (k == 1) begin : g_mul_scale
          assign nxt[k] = W'(scale(mul_ops(data_q[0][P-1:0])));
        end else begin : g_scale
          assign nxt[k] = W'(scale($signed(data_q[k-1][P-1:0])));
        end
      end else if (k == 1) begin : g_mul
        assign nxt[k] = W'($unsigned(mul_ops(data_q[0][P-1:0])));
      end else begin : g_pass
        assign nxt[k] = data_q[k-1];
      end
    end
  end

  // Stage k may load when the consumer takes the result or any stage from k onward is empty;
  // written without self-reference so the ready chain stays a plain combinational cone.
  always_comb begin
    load = '0;
    for (int k = 0; k < NUM_STAGE; k++) begin
      load[k] = bus.out_ready;
      for (int j = k; j < NUM_STAGE; j++) begin
        if (!valid_q[j]) load[k] = 1'b1;
      end
    end
  end

  // Advance the pipeline; payload only changes when a valid item moves in, so held results stay put.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < NUM_STAGE; k++) data_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_STAGE; k++) begin
        if (load[k]) begin
          valid_q[k] <= up_valid[k];
          if (up_valid[k]) data_q[k] <= nxt[k];
        end
      end
    end
  end

  assign bus.in_ready  = load[0];
  assign bus.out_valid = valid_q[NUM_STAGE-1];
  assign bus.dout      = data_q[NUM_STAGE-1][DOUT_W:1];
  assign bus.sat       = data_q[NUM_STAGE-1][0];

endmodule
